// File: rtl/dtcore32_lsu.sv
// dtcore32_lsu: memory-stage load/store unit.
// Decodes the EX/MEM memory op and checks alignment. It runs one access at a
// time on a req/gnt/rvalid data bus and stalls the pipeline until that access
// resolves. Load data, masks and trap info are presented on a one-cycle done_o.
// Optional build macro DTCORE32_LSU_TIMEOUT_EN adds a bus watchdog that raises
// an access-fault trap after TIMEOUT_CYCLES cycles in REQ or RESP.
//
// state | meaning
// IDLE  | waiting for a valid memory op; misaligned ops trap straight to DONE
// REQ   | dmem_req_o asserted, bus outputs held until dmem_gnt_i
// RESP  | granted, waiting for dmem_rvalid_i
// DONE  | results valid, done_o pulses unless the access was flushed
module dtcore32_lsu #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  input  logic [4:0]  mem_op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_wdata_i,
  input  logic        flush_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_wmask_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] load_rdata_o,
  output logic [3:0]  rmask_o,
  output logic [3:0]  wmask_o,
  output logic        trap_valid_o,
  output logic [31:0] trap_mcause_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  state_t state, state_next;

  logic        accept, misaligned;
  logic [1:0]  off, off_q, size_q;
  logic        uns_q, kill_q, kill_set;
  logic        finish, fin_trap, timeout;
  logic [31:0] fin_cause, wdata_d, load_ext;
  logic [3:0]  mask_d, mask_q;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign off        = addr_i[1:0];
  assign accept     = in_valid_i & mem_op_i[4] & ~flush_i;
  assign misaligned = mem_op_i[1] ? (off != 2'b00) : (mem_op_i[0] & off[0]);

  // Byte-lane mask and lane-replicated store data for the incoming op
  always_comb begin
    mask_d  = 4'b1111;
    wdata_d = store_wdata_i;
    case (mem_op_i[1:0])
      2'b00: begin
        mask_d  = 4'b0001 << off;
        wdata_d = {4{store_wdata_i[7:0]}};
      end
      2'b01: begin
        mask_d  = 4'b0011 << off;
        wdata_d = {2{store_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane_b = dmem_rdata_i[{off_q, 3'b000} +: 8];
  assign lane_h = dmem_rdata_i[{off_q[1], 4'b0000} +: 16];

  // Select the addressed lane of the read data and extend it
  always_comb begin
    load_ext = dmem_rdata_i;
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_ext = uns_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: ;
    endcase
  end

`ifdef DTCORE32_LSU_TIMEOUT_EN
  logic [31:0] wdog_q;

  // Watchdog down-counter, reloaded on every state change and outside REQ/RESP
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wdog_q <= '0;
    end else if ((state_next != state) || !((state == REQ) || (state == RESP))) begin
      wdog_q <= 32'(TIMEOUT_CYCLES - 1);
    end else if (wdog_q != '0) begin
      wdog_q <= wdog_q - 32'd1;
    end
  end

  assign timeout = ((state == REQ) || (state == RESP)) && (wdog_q == '0);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic, bus request, stall and result-capture strobes
  always_comb begin
    state_next = state;
    dmem_req_o = 1'b0;
    stall_o    = 1'b0;
    done_o     = 1'b0;
    finish     = 1'b0;
    fin_trap   = 1'b0;
    fin_cause  = 32'd0;
    kill_set   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall_o = 1'b1;
          if (misaligned) begin
            state_next = DONE;
            finish     = 1'b1;
            fin_trap   = 1'b1;
            fin_cause  = mem_op_i[3] ? 32'd6 : 32'd4;
          end else begin
            state_next = REQ;
          end
        end
      end
      REQ: begin
        dmem_req_o = 1'b1;
        stall_o    = 1'b1;
        if (dmem_gnt_i) begin
          kill_set = flush_i;
          if (dmem_rvalid_i) begin
            state_next = DONE;
            finish     = ~(kill_q | flush_i);
          end else begin
            state_next = RESP;
          end
        end else if (flush_i) begin
          state_next = IDLE;
        end else if (timeout) begin
          state_next = DONE;
          finish     = ~kill_q;
          fin_trap   = 1'b1;
          fin_cause  = dmem_we_o ? 32'd7 : 32'd5;
        end
      end
      RESP: begin
        stall_o  = 1'b1;
        kill_set = flush_i;
        if (dmem_rvalid_i) begin
          state_next = DONE;
          finish     = ~(kill_q | flush_i);
        end else if (timeout) begin
          state_next = DONE;
          finish     = ~(kill_q | flush_i);
          fin_trap   = 1'b1;
          fin_cause  = dmem_we_o ? 32'd7 : 32'd5;
        end
      end
      DONE: begin
        done_o     = ~kill_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign dmem_wmask_o = dmem_we_o ? mask_q : 4'b0000;

  // Access registers, kill flag and result outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      dmem_addr_o   <= '0;
      dmem_we_o     <= 1'b0;
      dmem_wdata_o  <= '0;
      mask_q        <= '0;
      off_q         <= '0;
      size_q        <= '0;
      uns_q         <= 1'b0;
      kill_q        <= 1'b0;
      load_rdata_o  <= '0;
      rmask_o       <= '0;
      wmask_o       <= '0;
      trap_valid_o  <= 1'b0;
      trap_mcause_o <= '0;
    end else begin
      if ((state == IDLE) && accept && !misaligned) begin
        dmem_addr_o  <= {addr_i[31:2], 2'b00};
        dmem_we_o    <= mem_op_i[3];
        dmem_wdata_o <= wdata_d;
        mask_q       <= mask_d;
        off_q        <= off;
        size_q       <= mem_op_i[1:0];
        uns_q        <= mem_op_i[2];
      end
      if (state_next == IDLE) kill_q <= 1'b0;
      else if (kill_set)      kill_q <= 1'b1;
      if (finish) begin
        trap_valid_o  <= fin_trap;
        trap_mcause_o <= fin_cause;
        if (fin_trap) begin
          load_rdata_o <= '0;
          rmask_o      <= '0;
          wmask_o      <= '0;
        end else if (dmem_we_o) begin
          load_rdata_o <= '0;
          rmask_o      <= '0;
          wmask_o      <= mask_q;
        end else begin
          load_rdata_o <= load_ext;
          rmask_o      <= mask_q;
          wmask_o      <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dtcore32_lsu.sv
// tb_dtcore32_lsu: directed bench for dtcore32_lsu with a result scoreboard.
module tb_dtcore32_lsu;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic [4:0]  mem_op_i;
  logic [31:0] addr_i;
  logic [31:0] store_wdata_i;
  logic        flush_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_wmask_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] load_rdata_o;
  logic [3:0]  rmask_o;
  logic [3:0]  wmask_o;
  logic        trap_valid_o;
  logic [31:0] trap_mcause_o;

  typedef struct {
    logic [31:0] rdata;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic        trap;
    logic [31:0] cause;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   done_snap;

  dtcore32_lsu #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .mem_op_i(mem_op_i),
    .addr_i(addr_i), .store_wdata_i(store_wdata_i), .flush_i(flush_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wmask_o(dmem_wmask_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o),
    .done_o(done_o), .load_rdata_o(load_rdata_o), .rmask_o(rmask_o), .wmask_o(wmask_o),
    .trap_valid_o(trap_valid_o), .trap_mcause_o(trap_mcause_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rd, input logic [3:0] rm,
                              input logic [3:0] wm, input logic tr, input logic [31:0] c);
    exp_t e;
    e.rdata = rd; e.rmask = rm; e.wmask = wm; e.trap = tr; e.cause = c;
    return e;
  endfunction

  // Scoreboard: every done pulse pops the oldest expected result
  always @(negedge clk_i) begin
    if (rst_ni && done_o) begin
      exp_t e;
      done_cnt++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected_done observed=%0d expected=%0d", 1, 0);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_load_rdata", load_rdata_o, e.rdata);
        chk("sb_rmask", 32'(rmask_o), 32'(e.rmask));
        chk("sb_wmask", 32'(wmask_o), 32'(e.wmask));
        chk("sb_trap_valid", 32'(trap_valid_o), 32'(e.trap));
        chk("sb_trap_mcause", trap_mcause_o, e.cause);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Aligned access whose grant and response arrive in the first REQ cycle
  task automatic do_imm(input string tag, input logic [4:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input logic [31:0] bus_wd, input logic [3:0] bus_wm);
    in_valid_i = 1'b1; mem_op_i = op; addr_i = addr; store_wdata_i = wd;
    #1;
    chk({tag, "_stall_accept"}, 32'(stall_o), 32'd1);
    tick();
    in_valid_i = 1'b0; mem_op_i = 5'd0;
    chk({tag, "_req"}, 32'(dmem_req_o), 32'd1);
    chk({tag, "_addr"}, dmem_addr_o, {addr[31:2], 2'b00});
    chk({tag, "_bus_wdata"}, dmem_wdata_o, bus_wd);
    chk({tag, "_bus_wmask"}, 32'(dmem_wmask_o), 32'(bus_wm));
    chk({tag, "_stall_req"}, 32'(stall_o), 32'd1);
    dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = rd;
    tick();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    chk({tag, "_done"}, 32'(done_o), 32'd1);
    chk({tag, "_stall_done"}, 32'(stall_o), 32'd0);
    tick();
    chk({tag, "_done_one_cycle"}, 32'(done_o), 32'd0);
  endtask

  // Misaligned access: no bus request, trap reported the next cycle
  task automatic do_trap(input string tag, input logic [4:0] op, input logic [31:0] addr);
    in_valid_i = 1'b1; mem_op_i = op; addr_i = addr; store_wdata_i = 32'h1111_2222;
    #1;
    chk({tag, "_stall"}, 32'(stall_o), 32'd1);
    chk({tag, "_noreq_accept"}, 32'(dmem_req_o), 32'd0);
    tick();
    in_valid_i = 1'b0; mem_op_i = 5'd0;
    chk({tag, "_done"}, 32'(done_o), 32'd1);
    chk({tag, "_noreq_done"}, 32'(dmem_req_o), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=%0d", 0, 1);
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_ni = 1'b0; in_valid_i = 1'b0; mem_op_i = 5'd0; addr_i = '0; store_wdata_i = '0;
    flush_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    repeat (3) tick();
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_load_rdata", load_rdata_o, 32'd0);
    chk("rst_trap", 32'(trap_valid_o), 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    rst_ni = 1'b1;
    tick();

    // LB 0x1003: top lane 0x80 sign-extends
    sb.push_back(mk(32'hFFFF_FF80, 4'b1000, 4'b0000, 1'b0, 32'd0));
    do_imm("lb", 5'b10000, 32'h0000_1003, 32'd0, 32'h80FF_FF12, 32'd0, 4'b0000);

    // SH 0x2002 with grant delayed three cycles
    sb.push_back(mk(32'd0, 4'b0000, 4'b1100, 1'b0, 32'd0));
    in_valid_i = 1'b1; mem_op_i = 5'b11001; addr_i = 32'h0000_2002; store_wdata_i = 32'h1234_ABCD;
    #1;
    chk("sh_stall_accept", 32'(stall_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      in_valid_i = 1'b0; mem_op_i = 5'd0;
      chk("sh_req_wait", 32'(dmem_req_o), 32'd1);
      chk("sh_addr_stable", dmem_addr_o, 32'h0000_2000);
      chk("sh_bus_wmask", 32'(dmem_wmask_o), 32'(4'b1100));
      chk("sh_bus_wdata", dmem_wdata_o, 32'hABCD_ABCD);
      chk("sh_we", 32'(dmem_we_o), 32'd1);
    end
    tick();
    chk("sh_req_before_gnt", 32'(dmem_req_o), 32'd1);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    chk("sh_req_dropped", 32'(dmem_req_o), 32'd0);
    chk("sh_stall_resp", 32'(stall_o), 32'd1);
    chk("sh_no_early_done", 32'(done_o), 32'd0);
    dmem_rvalid_i = 1'b1;
    tick();
    dmem_rvalid_i = 1'b0;
    chk("sh_done", 32'(done_o), 32'd1);
    tick();

    // Misaligned word load and store
    sb.push_back(mk(32'd0, 4'b0000, 4'b0000, 1'b1, 32'd4));
    do_trap("lw_mis", 5'b10010, 32'h0000_3001);
    sb.push_back(mk(32'd0, 4'b0000, 4'b0000, 1'b1, 32'd6));
    do_trap("sw_mis", 5'b11010, 32'h0000_3002);

    // Remaining size/sign combinations
    sb.push_back(mk(32'hFFFF_8001, 4'b1100, 4'b0000, 1'b0, 32'd0));
    do_imm("lh", 5'b10001, 32'h0000_4002, 32'd0, 32'h8001_7FFF, 32'd0, 4'b0000);
    sb.push_back(mk(32'h0000_009A, 4'b0010, 4'b0000, 1'b0, 32'd0));
    do_imm("lbu", 5'b10100, 32'h0000_5001, 32'd0, 32'h0000_9A00, 32'd0, 4'b0000);
    sb.push_back(mk(32'hDEAD_BEEF, 4'b1111, 4'b0000, 1'b0, 32'd0));
    do_imm("lw", 5'b10010, 32'h0000_6000, 32'd0, 32'hDEAD_BEEF, 32'd0, 4'b0000);
    sb.push_back(mk(32'd0, 4'b0000, 4'b0100, 1'b0, 32'd0));
    do_imm("sb", 5'b11000, 32'h0000_7002, 32'h0000_0055, 32'd0, 32'h5555_5555, 4'b0100);
    sb.push_back(mk(32'd0, 4'b0000, 4'b1111, 1'b0, 32'd0));
    do_imm("sw", 5'b11010, 32'h0000_7004, 32'hCAFE_BABE, 32'd0, 32'hCAFE_BABE, 4'b1111);

    // LHU flushed in REQ before grant
    done_snap = done_cnt;
    in_valid_i = 1'b1; mem_op_i = 5'b10101; addr_i = 32'h0000_4000;
    tick();
    in_valid_i = 1'b0; mem_op_i = 5'd0;
    chk("fl_req_req", 32'(dmem_req_o), 32'd1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("fl_req_dropped", 32'(dmem_req_o), 32'd0);
    chk("fl_req_stall", 32'(stall_o), 32'd0);
    tick();
    chk("fl_req_no_done", 32'(done_cnt), 32'(done_snap));

    // LHU flushed in RESP: response consumed silently
    in_valid_i = 1'b1; mem_op_i = 5'b10101; addr_i = 32'h0000_4000;
    tick();
    in_valid_i = 1'b0; mem_op_i = 5'd0;
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("fl_resp_still_waiting", 32'(stall_o), 32'd1);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
    tick();
    dmem_rvalid_i = 1'b0;
    chk("fl_resp_killed_done", 32'(done_o), 32'd0);
    tick();
    chk("fl_resp_idle_stall", 32'(stall_o), 32'd0);
    chk("fl_resp_idle_req", 32'(dmem_req_o), 32'd0);
    chk("fl_resp_no_done", 32'(done_cnt), 32'(done_snap));

    // Reset while in RESP, then a stray response
    in_valid_i = 1'b1; mem_op_i = 5'b10010; addr_i = 32'h0000_8000;
    tick();
    in_valid_i = 1'b0; mem_op_i = 5'd0;
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    chk("rr_in_resp", 32'(stall_o), 32'd1);
    rst_ni = 1'b0;
    tick();
    chk("rr_req", 32'(dmem_req_o), 32'd0);
    chk("rr_stall", 32'(stall_o), 32'd0);
    chk("rr_wmask", 32'(wmask_o), 32'd0);
    chk("rr_addr", dmem_addr_o, 32'd0);
    chk("rr_wdata", dmem_wdata_o, 32'd0);
    chk("rr_mcause", trap_mcause_o, 32'd0);
    rst_ni = 1'b1;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
    tick();
    dmem_rvalid_i = 1'b0;
    tick();
    chk("rr_stray_no_done", 32'(done_cnt), 32'(done_snap));
    chk("rr_stray_stall", 32'(stall_o), 32'd0);

`ifdef DTCORE32_LSU_TIMEOUT_EN
    // Load never granted: watchdog fires after 8 cycles in REQ
    sb.push_back(mk(32'd0, 4'b0000, 4'b0000, 1'b1, 32'd5));
    in_valid_i = 1'b1; mem_op_i = 5'b10010; addr_i = 32'h0000_9000;
    for (int i = 0; i < 8; i++) begin
      tick();
      in_valid_i = 1'b0; mem_op_i = 5'd0;
      chk("to_req_held", 32'(dmem_req_o), 32'd1);
    end
    tick();
    chk("to_done", 32'(done_o), 32'd1);
    chk("to_req_dropped", 32'(dmem_req_o), 32'd0);
    chk("to_stall_released", 32'(stall_o), 32'd0);
    tick();
`endif

    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
